// File: rtl/regfilen.sv
// DEPTH x N register file: one synchronous write port, two combinational read ports and a
// sequential clear sweep that reports busy. Define REGFILEN_BYPASS_EN for write-to-read bypass.
module regfilen #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [N-1:0]  rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [N-1:0]  rdata_b,
  input  logic          clr,
  output logic          busy
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic [N-1:0]  mem_q [DEPTH];
  logic [N-1:0]  mem_d [DEPTH];
  logic          wr_en;

  // Address may exceed DEPTH-1 when DEPTH is not a power of two.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  assign wr_en = (state_q == StIdle) && we && addr_ok(waddr);
  assign busy  = busy_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (clr) state_d = StClear;
      StClear: if (idx_q == LastIdx) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    idx_d  = '0;
    busy_d = (state_d == StClear);
    unique case (state_q)
      StIdle: begin
        if (wr_en) mem_d[waddr] = wdata;
      end
      StClear: begin
        mem_d[idx_q] = '0;
        idx_d        = (idx_q == LastIdx) ? '0 : idx_q + AW'(1);
      end
      default: ;
    endcase
  end

  // Read ports
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (addr_ok(raddr_a)) rdata_a = mem_q[raddr_a];
    if (addr_ok(raddr_b)) rdata_b = mem_q[raddr_b];
`ifdef REGFILEN_BYPASS_EN
    if (wr_en && (raddr_a == waddr)) rdata_a = wdata;
    if (wr_en && (raddr_b == waddr)) rdata_b = wdata;
`endif
  end

endmodule
